// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO register pair.
// Divide support (DIVU/DIV) is built only when MULDIV_DIVIDE_EN is defined.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic                 sgn_op;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;
    logic [2*WIDTH-1:0]   prod;

`ifdef MULDIV_DIVIDE_EN
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 is_div_q, is_div_d;
    logic                 rneg_q, rneg_d;
    logic                 div0_q, div0_d;
    logic [WIDTH:0]       div_r, div_diff;
    logic [2*WIDTH-1:0]   div_step;
`endif

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MULDIV_DIVIDE_EN
        b_d      = b_q;
        is_div_d = is_div_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        accept   = (state_q == S_IDLE) && start;
`else
        accept   = (state_q == S_IDLE) && start && !op[1];
`endif

        sgn_op = op[0];
        mag_a  = magnitude(srca, sgn_op);
        mag_b  = magnitude(srcb, sgn_op);

        // Multiplier sits in the low half of acc and shifts out as the product shifts in.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};
        prod     = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIVIDE_EN
        // Restoring step: remainder in the high half, quotient bits enter at the bottom.
        div_r    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_r - {1'b0, b_q};
        div_step = div_diff[WIDTH] ? {div_r[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                    cnt_d   = CNT_W'(WIDTH);
                    neg_d   = sgn_op && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                    a_d     = mag_a;
                    acc_d   = {{WIDTH{1'b0}}, mag_b};
`ifdef MULDIV_DIVIDE_EN
                    is_div_d = op[1];
                    rneg_d   = sgn_op && srca[WIDTH-1];
                    div0_d   = (srcb == '0);
                    b_d      = mag_b;
                    if (op[1]) begin
                        // Raw dividend is kept for the divide-by-zero HI result.
                        a_d   = srca;
                        acc_d = {{WIDTH{1'b0}}, mag_a};
                    end
`endif
                end else begin
                    if (we_hi) hi_d = wdata;
                    if (we_lo) lo_d = wdata;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 1'b1;
`ifdef MULDIV_DIVIDE_EN
                acc_d = is_div_q ? div_step : mul_step;
`else
                acc_d = mul_step;
`endif
                if (cnt_q == CNT_W'(1)) state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                hi_d    = prod[2*WIDTH-1:WIDTH];
                lo_d    = prod[WIDTH-1:0];
`ifdef MULDIV_DIVIDE_EN
                if (is_div_q) begin
                    if (div0_q) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        lo_d = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
            b_q      <= '0;
            is_div_q <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MULDIV_DIVIDE_EN
            b_q      <= b_d;
            is_div_q <= is_div_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: expected HI/LO and done cycle are queued at
// launch and checked by an independent monitor on every done pulse.
module tb_hilo_muldiv_unit;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  srca, srcb;
    logic          we_hi, we_lo;
    logic [W-1:0]  wdata;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    hilo_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .we_hi (we_hi),
        .we_lo (we_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 of the operation.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic expect_done, input logic [W-1:0] eh, input logic [W-1:0] el);
        exp_t e;
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        if (expect_done) begin
            e.hi  = eh;
            e.lo  = el;
            e.cyc = cyc + LAT;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {{(W-1){1'b0}}, done}, '0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_hi", hi, e.hi);
                check("result_lo", lo, e.lo);
                check("done_cycle", W'(cyc), W'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
        we_hi = 1'b0; we_lo = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_hi", hi, '0);
        check("reset_lo", lo, '0);
        check("reset_busy", {31'b0, busy}, '0);
        check("reset_done", {31'b0, done}, '0);
        reset = 1'b0;
        @(negedge clk);

        // MTHI / MTLO in IDLE, separately then together
        we_hi = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        we_hi = 1'b0;
        check("mthi", hi, 32'h0000_1234);
        we_lo = 1'b1; wdata = 32'h0000_5678;
        @(negedge clk);
        we_lo = 1'b0;
        check("mtlo", lo, 32'h0000_5678);
        check("mtlo_hi_kept", hi, 32'h0000_1234);
        we_hi = 1'b1; we_lo = 1'b1; wdata = 32'hA5A5_0F0F;
        @(negedge clk);
        we_hi = 1'b0; we_lo = 1'b0;
        check("mt_both_hi", hi, 32'hA5A5_0F0F);
        check("mt_both_lo", lo, 32'hA5A5_0F0F);

        // Reset in the middle of a MULTU: nothing written, no done ever
        launch(2'b00, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, '0, '0);
        repeat (9) @(negedge clk);
        check("midrun_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, '0);
        check("abort_hi", hi, '0);
        check("abort_lo", lo, '0);
        repeat (40) @(negedge clk);

        // MULTU max x max, with MTLO on the start cycle and MTHI/start while busy
        we_lo = 1'b1; wdata = 32'h0000_5555;
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
        we_lo = 1'b0;
        check("start_cycle_mtlo_ignored", lo, '0);
        check("busy_c1", {31'b0, busy}, 32'd1);
        for (int c = 2; c <= 33; c++) begin
            @(negedge clk);
            check("busy_window", {31'b0, busy}, 32'd1);
            if (c == 5) begin
                we_hi = 1'b1; wdata = 32'h0000_DEAD;
                start = 1'b1; op = 2'b01; srca = 32'd2; srcb = 32'd2;
            end
            if (c == 6) begin
                we_hi = 1'b0; start = 1'b0;
                check("busy_mthi_ignored", hi, '0);
            end
        end
        @(negedge clk);
        check("busy_c34", {31'b0, busy}, '0);

        // Back-to-back chain, each start issued in the previous done cycle
        launch(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        repeat (33) @(negedge clk);
        launch(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);
        repeat (33) @(negedge clk);
        launch(2'b01, 32'h0000_0005, 32'hFFFF_FFFA, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE2);
        repeat (33) @(negedge clk);
        launch(2'b00, 32'h1234_5678, 32'h0000_0010, 1'b1, 32'h0000_0001, 32'h2345_6780);
        repeat (33) @(negedge clk);
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001);
        repeat (34) @(negedge clk);

`ifdef MULDIV_DIVIDE_EN
        launch(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        repeat (33) @(negedge clk);
        launch(2'b10, 32'd100, 32'd0, 1'b1, 32'd100, 32'hFFFF_FFFF);
        repeat (33) @(negedge clk);
        launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000);
        repeat (33) @(negedge clk);
        launch(2'b10, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
        repeat (33) @(negedge clk);
        launch(2'b11, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD);
        repeat (33) @(negedge clk);
        launch(2'b11, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        repeat (34) @(negedge clk);
`else
        // Divide ops are rejected outright when the divider is not built
        launch(2'b10, 32'd100, 32'd7, 1'b0, '0, '0);
        check("nodiv_busy_c1", {31'b0, busy}, '0);
        launch(2'b11, 32'd100, 32'd7, 1'b0, '0, '0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c % 8 == 0) check("nodiv_busy", {31'b0, busy}, '0);
        end
        check("nodiv_hi", hi, 32'h0000_0000);
        check("nodiv_lo", lo, 32'h0000_0001);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", W'(sb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
